// File: rtl/servo_pwm_pkg.sv
// Shared defaults and helpers for the multi-channel servo PWM block.
package servo_pwm_pkg;

    localparam int unsigned DEF_PERIOD    = 1000;
    localparam int unsigned DEF_DUTY_MIN  = 25;
    localparam int unsigned DEF_DUTY_MAX  = 125;
    localparam int unsigned DEF_DUTY_RST  = 27;
    localparam int unsigned DEF_RAMP_STEP = 2;

    // Bits needed to encode 0..n-1, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned clamp(input int unsigned v,
                                          input int unsigned lo,
                                          input int unsigned hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo channel: double-buffered duty (shadow/active) and the registered compare output.
// With SERVO_PWM_RAMP_EN defined, active slews toward shadow by at most RAMP_STEP per frame.
module servo_pwm_chan #(
    parameter int unsigned CW        = 10,
`ifdef SERVO_PWM_RAMP_EN
    parameter int unsigned RAMP_STEP = 2,
`endif
    parameter int unsigned DUTY_RST  = 27
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          running,
    input  logic          load,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_duty,
    input  logic [CW-1:0] cnt,
    output logic          pwm
);

    logic [CW-1:0] shadow_q;
    logic [CW-1:0] active_q;
    logic [CW-1:0] active_d;
    logic          pwm_q;

`ifdef SERVO_PWM_RAMP_EN
    localparam logic [CW-1:0] Step = CW'(RAMP_STEP);

    always_comb begin
        active_d = shadow_q;
        if (shadow_q > active_q) begin
            if (shadow_q - active_q > Step) begin
                active_d = active_q + Step;
            end
        end else if (active_q - shadow_q > Step) begin
            active_d = active_q - Step;
        end
    end
`else
    always_comb begin
        active_d = shadow_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= CW'(DUTY_RST);
            active_q <= CW'(DUTY_RST);
            pwm_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow_q <= wr_duty;
            end
            // A write landing on the load edge stays in shadow until the next frame.
            if (load) begin
                active_q <= active_d;
            end
            pwm_q <= running && (cnt < active_q);
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM generator: shared frame counter, duty write port, per-channel outputs.
// Optional duty slew limiting is enabled by defining SERVO_PWM_RAMP_EN.
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned PERIOD    = DEF_PERIOD,
    parameter int unsigned DUTY_MIN  = DEF_DUTY_MIN,
    parameter int unsigned DUTY_MAX  = DEF_DUTY_MAX,
    parameter int unsigned DUTY_RST  = DEF_DUTY_RST,
    parameter int unsigned RAMP_STEP = DEF_RAMP_STEP,
    localparam int unsigned CHW      = width_of(NCH),
    localparam int unsigned CW       = width_of(PERIOD + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_duty,
    output logic           wr_err,
    output logic           frame_start,
    output logic [NCH-1:0] pwm_out
);

    if (!(NCH >= 1 && NCH <= 16 && DUTY_MIN <= DUTY_RST && DUTY_RST <= DUTY_MAX &&
          DUTY_MAX < PERIOD && RAMP_STEP < PERIOD)) begin : g_bad_params
        $error("servo_pwm_multi: illegal parameter combination");
    end

    logic [CW-1:0]  cnt_q;
    logic           run_q;
    logic           frame_start_q;
    logic           wr_ready_q;
    logic           wr_err_q;

    logic           running;
    logic           wrap;
    logic           arm;
    logic           load;
    logic           wr_fire;
    logic           wr_bad;
    logic [CW-1:0]  duty_clamped;
    logic [NCH-1:0] pwm;

    // arm: first enabled cycle after reset or a disable. It spends one cycle at cnt=0 loading
    // active and raising frame_start, so the fresh frame looks exactly like one after a wrap.
    always_comb begin
        running      = enable && run_q;
        wrap         = running && (cnt_q == CW'(PERIOD - 1));
        arm          = enable && !run_q;
        load         = wrap || arm;
        wr_fire      = wr_valid && wr_ready_q;
        wr_bad       = (32'(wr_ch) >= NCH);
        duty_clamped = CW'(clamp(32'(wr_duty), DUTY_MIN, DUTY_MAX));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            run_q         <= 1'b0;
            frame_start_q <= 1'b0;
            wr_ready_q    <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            run_q         <= enable;
            frame_start_q <= load;
            wr_ready_q    <= 1'b1;
            wr_err_q      <= wr_fire && wr_bad;
            if (!enable || load) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic wr_en;
        assign wr_en = wr_fire && !wr_bad && (32'(wr_ch) == i);

        servo_pwm_chan #(
            .CW       (CW),
`ifdef SERVO_PWM_RAMP_EN
            .RAMP_STEP(RAMP_STEP),
`endif
            .DUTY_RST (DUTY_RST)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .running(running),
            .load   (load),
            .wr_en  (wr_en),
            .wr_duty(duty_clamped),
            .cnt    (cnt_q),
            .pwm    (pwm[i])
        );
    end

    assign wr_ready    = wr_ready_q;
    assign wr_err      = wr_err_q;
    assign frame_start = frame_start_q;
    assign pwm_out     = pwm;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: directed scenarios plus random traffic against a frame-position model.
// Build with SERVO_PWM_RAMP_EN defined to exercise the slew-limited variant.
module tb_servo_pwm_multi;

    localparam int NCH    = 3;
    localparam int PERIOD = 1000;
    localparam int DMIN   = 25;
    localparam int DMAX   = 125;
    localparam int DRST   = 27;
    localparam int STEP   = 2;
    localparam int CHW    = 2;
    localparam int CW     = 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic           wr_valid;
    logic           wr_ready;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_duty;
    logic           wr_err;
    logic           frame_start;
    logic [NCH-1:0] pwm_out;

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .NCH      (NCH),
        .PERIOD   (PERIOD),
        .DUTY_MIN (DMIN),
        .DUTY_MAX (DMAX),
        .DUTY_RST (DRST),
        .RAMP_STEP(STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_ch      (wr_ch),
        .wr_duty    (wr_duty),
        .wr_err     (wr_err),
        .frame_start(frame_start),
        .pwm_out    (pwm_out)
    );

    int checks   = 0;
    int failures = 0;

    // Model: m_pos is the position inside the current frame (0 = first cycle), -1 when idle.
    int m_pos;
    int m_shadow[NCH];
    int m_active[NCH];
    bit m_ready;
    bit m_err;
    bit m_fs;
    int meas[NCH];

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int clamp_duty(input int v);
        if (v < DMIN) return DMIN;
        if (v > DMAX) return DMAX;
        return v;
    endfunction

    function automatic int next_duty(input int act, input int sh);
`ifdef SERVO_PWM_RAMP_EN
        if (sh - act > STEP) return act + STEP;
        if (act - sh > STEP) return act - STEP;
`endif
        return sh;
    endfunction

    // High for frame positions 1..duty: one cycle of output latency behind the frame start.
    function automatic int exp_pwm();
        int v = 0;
        for (int i = 0; i < NCH; i++) begin
            if (m_pos >= 1 && m_pos <= m_active[i]) v |= (1 << i);
        end
        return v;
    endfunction

    task automatic model_step();
        int sh_next[NCH];
        bit fire;
        bit load;
        if (!rst_n) begin
            m_pos   = -1;
            m_ready = 1'b0;
            m_err   = 1'b0;
            m_fs    = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_shadow[i] = DRST;
                m_active[i] = DRST;
            end
            return;
        end
        fire    = wr_valid && m_ready;
        m_err   = fire && (int'(wr_ch) >= NCH);
        m_ready = 1'b1;
        sh_next = m_shadow;
        if (fire && int'(wr_ch) < NCH) sh_next[int'(wr_ch)] = clamp_duty(int'(wr_duty));
        load = 1'b0;
        if (!enable) begin
            m_pos = -1;
        end else if (m_pos < 0 || m_pos == PERIOD - 1) begin
            load  = 1'b1;
            m_pos = 0;
        end else begin
            m_pos++;
        end
        m_fs = load;
        if (load) begin
            for (int i = 0; i < NCH; i++) m_active[i] = next_duty(m_active[i], m_shadow[i]);
        end
        m_shadow = sh_next;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pwm_out", int'(pwm_out), exp_pwm());
        check("frame_start", int'(frame_start), int'(m_fs));
        check("wr_ready", int'(wr_ready), int'(m_ready));
        check("wr_err", int'(wr_err), int'(m_err));
    endtask

    task automatic write(input int ch, input int duty);
        wr_valid = 1'b1;
        wr_ch    = CHW'(ch);
        wr_duty  = CW'(duty);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic run_to(input int p);
        int n = 0;
        while (m_pos != p && n < 3 * PERIOD) begin
            tick();
            n++;
        end
        check("run_to", m_pos, p);
    endtask

    // Counts high cycles of each channel over one whole frame starting at the next frame start.
    task automatic measure_frame();
        run_to(0);
        for (int i = 0; i < NCH; i++) meas[i] = 0;
        repeat (PERIOD) begin
            tick();
            for (int i = 0; i < NCH; i++) meas[i] += int'(pwm_out[i]);
        end
    endtask

    initial begin
        int ramp_exp[5];
`ifdef SERVO_PWM_RAMP_EN
        ramp_exp = '{29, 31, 33, 35, 35};
`else
        ramp_exp = '{35, 35, 35, 35, 35};
`endif
        rst_n    = 1'b0;
        enable   = 1'b1;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_duty  = '0;
        repeat (3) tick();
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_ready", int'(wr_ready), 0);
        rst_n = 1'b1;

        for (int f = 0; f < 3; f++) begin
            measure_frame();
            for (int i = 0; i < NCH; i++) check("idle_duty", meas[i], DRST);
        end

        run_to(500);
        write(2, 35);
        for (int f = 0; f < 5; f++) begin
            measure_frame();
            check("ramp_ch2", meas[2], ramp_exp[f]);
        end

        run_to(500);
        write(1, 57);
        measure_frame();
        check("ch0_unchanged", meas[0], DRST);
`ifdef SERVO_PWM_RAMP_EN
        check("ch1_commit", meas[1], 29);
`else
        check("ch1_commit", meas[1], 57);
`endif

        run_to(PERIOD - 1);
        write(0, 60);
        measure_frame();
        check("wrap_write_late", meas[0], DRST);
        measure_frame();
`ifdef SERVO_PWM_RAMP_EN
        check("wrap_write_commit", meas[0], 29);
`else
        check("wrap_write_commit", meas[0], 60);
`endif

        run_to(100);
        write(0, 5);
        measure_frame();
`ifndef SERVO_PWM_RAMP_EN
        check("clamp_low", meas[0], DMIN);
`endif
        run_to(100);
        write(0, 900);
        measure_frame();
`ifndef SERVO_PWM_RAMP_EN
        check("clamp_high", meas[0], DMAX);
`endif
        run_to(200);
        write(3, 77);
        check("bad_ch_err", int'(wr_err), 1);
        tick();
        check("bad_ch_err_end", int'(wr_err), 0);

        run_to(100);
        write(1, 40);
        write(1, 70);
        measure_frame();

        run_to(10);
        enable = 1'b0;
        tick();
        check("disable_low", int'(pwm_out), 0);
        repeat (9) tick();
        enable = 1'b1;
        tick();
        check("reenable_fs", int'(frame_start), 1);
        measure_frame();

        run_to(40);
        write(1, 100);
        rst_n = 1'b0;
        tick();
        check("midreset_pwm", int'(pwm_out), 0);
        rst_n = 1'b1;
        measure_frame();
        for (int i = 0; i < NCH; i++) check("post_reset_duty", meas[i], DRST);

        for (int c = 0; c < 6000; c++) begin
            wr_valid = ($urandom_range(0, 7) == 0);
            wr_ch    = CHW'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                wr_duty = CW'(($urandom_range(0, 1) == 0) ? $urandom_range(22, 28)
                                                          : $urandom_range(122, 128));
            else
                wr_duty = CW'($urandom_range(0, 1023));
            if ($urandom_range(0, 599) == 0) enable = ~enable;
            rst_n = ($urandom_range(0, 2999) != 0);
            tick();
        end
        wr_valid = 1'b0;
        rst_n    = 1'b1;
        enable   = 1'b1;
        measure_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
